rps_match: RTL

RPS_MATCH -- requirements
Module: rps_match

---
 rtl/rps_match.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rps_match.sv
// Rock-paper-scissors match referee: scores move pairs round by round until a player reaches WIN_TARGET or MAX_ROUNDS pass.
// Latency: a pair accepted on edge N is reported (round_done, round_result, scores) in the cycle after edge N.
// Backpressure: move_ready is high only while a match is in play; move_valid at any other time is ignored.
//
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   start                            - clear scores and begin a new match (wins over a same-cycle move)
//   move_valid, A, B                 - move pair handshake; accepted when move_valid && move_ready
//   move_ready                       - high in PLAY
//   round_done, round_result         - one-cycle pulse with 00 draw / 01 A / 10 B / 11 invalid
//   score_A, score_B, round_count    - per-match counters
//   match_over, match_winner         - high in DONE; winner 01 A, 10 B, 00 undecided
//   error_count                      - invalid-round count, present only with RPS_MATCH_ERROR_COUNT_EN defined
module rps_match #(
    parameter logic [1:0] ROCK        = 2'b00,
    parameter logic [1:0] PAPER       = 2'b01,
    parameter logic [1:0] SCISORS     = 2'b10,
    parameter int         SCORE_WIDTH = 4,
    parameter int         WIN_TARGET  = 3,
    parameter int         MAX_ROUNDS  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   move_valid,
    input  logic [1:0]             A,
    input  logic [1:0]             B,
    output logic                   move_ready,
    output logic                   round_done,
    output logic [1:0]             round_result,
    output logic [SCORE_WIDTH-1:0] score_A,
    output logic [SCORE_WIDTH-1:0] score_B,
    output logic [SCORE_WIDTH-1:0] round_count,
    output logic                   match_over,
    output logic [1:0]             match_winner
`ifdef RPS_MATCH_ERROR_COUNT_EN
    ,
    output logic [SCORE_WIDTH-1:0] error_count
`endif
);

    localparam logic [SCORE_WIDTH-1:0] ONE     = SCORE_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] WIN_T   = SCORE_WIDTH'(WIN_TARGET);
    localparam logic [SCORE_WIDTH-1:0] MAX_R   = SCORE_WIDTH'(MAX_ROUNDS);

    localparam logic [1:0] RES_DRAW  = 2'b00;
    localparam logic [1:0] RES_A     = 2'b01;
    localparam logic [1:0] RES_B     = 2'b10;
    localparam logic [1:0] RES_INVAL = 2'b11;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t                  state_q, state_n;
    logic                    done_q, done_n;
    logic [1:0]              result_q, result_n;
    logic [SCORE_WIDTH-1:0]  sa_q, sa_n, sb_q, sb_n, cnt_q, cnt_n;
    logic [1:0]              winner_q, winner_n;

    logic                    accept;
    logic                    a_ok, b_ok;
    logic [1:0]              decision;

    // Round decision for the pair currently on A/B.
    always_comb begin
        a_ok = (A == ROCK) || (A == PAPER) || (A == SCISORS);
        b_ok = (B == ROCK) || (B == PAPER) || (B == SCISORS);
        if (!a_ok || !b_ok)
            decision = RES_INVAL;
        else if (A == B)
            decision = RES_DRAW;
        else if ((A == PAPER && B == ROCK) || (A == ROCK && B == SCISORS) ||
                 (A == SCISORS && B == PAPER))
            decision = RES_A;
        else
            decision = RES_B;
    end

    // start takes priority, so a move presented alongside it is dropped.
    assign accept = (state_q == PLAY) && move_valid && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= RES_DRAW;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_n;
            done_q   <= done_n;
            result_q <= result_n;
            sa_q     <= sa_n;
            sb_q     <= sb_n;
            cnt_q    <= cnt_n;
            winner_q <= winner_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        done_n   = 1'b0;
        result_n = result_q;
        sa_n     = sa_q;
        sb_n     = sb_q;
        cnt_n    = cnt_q;
        winner_n = winner_q;

        if (start) begin
            state_n  = PLAY;
            result_n = RES_DRAW;
            sa_n     = '0;
            sb_n     = '0;
            cnt_n    = '0;
            winner_n = 2'b00;
        end else if (accept) begin
            done_n   = 1'b1;
            result_n = decision;
            cnt_n    = cnt_q + ONE;
            if (decision == RES_A) sa_n = sa_q + ONE;
            if (decision == RES_B) sb_n = sb_q + ONE;
            // Leaving PLAY as soon as a limit is hit is what keeps the counters
            // from ever passing WIN_TARGET / MAX_ROUNDS.
            if (sa_n == WIN_T) begin
                state_n  = DONE;
                winner_n = RES_A;
            end else if (sb_n == WIN_T) begin
                state_n  = DONE;
                winner_n = RES_B;
            end else if (cnt_n == MAX_R) begin
                state_n  = DONE;
                winner_n = 2'b00;
            end
        end
    end

    assign move_ready   = (state_q == PLAY);
    assign match_over   = (state_q == DONE);
    assign round_done   = done_q;
    assign round_result = result_q;
    assign score_A      = sa_q;
    assign score_B      = sb_q;
    assign round_count  = cnt_q;
    assign match_winner = winner_q;

`ifdef RPS_MATCH_ERROR_COUNT_EN
    logic [SCORE_WIDTH-1:0] err_q;

    // Saturating: sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= '0;
        else if (start)
            err_q <= '0;
        else if (accept && decision == RES_INVAL && err_q != '1)
            err_q <= err_q + ONE;
    end

    assign error_count = err_q;
`endif

endmodule
